// File: rtl/sample_capture_pkg.sv
// Shared types for the sample capture path: FSM state encoding, the ADC
// sample type and the edge-crossing compare used by trigger detection.
package sample_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef logic [7:0] sample_t;

    // Unsigned level crossing between two consecutive kept samples.
    function automatic logic edge_hit(input sample_t prev, input sample_t cur,
                                      input sample_t level, input logic falling);
        if (falling) begin
            return (prev > level) && (cur <= level);
        end
        return (prev < level) && (cur >= level);
    endfunction

endpackage

// File: rtl/trigger_detect.sv
// Remembers the previous kept sample while armed and flags a level crossing
// on the current kept sample. The first kept sample after a clear only primes
// the history and can never fire.
module trigger_detect
    import sample_capture_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clear,
    input  logic    strobe,
    input  sample_t sample,
    input  sample_t level,
    input  logic    falling,
    output logic    fire
);

    sample_t prev_q, prev_d;
    logic    prev_valid_q, prev_valid_d;

    // History update: cleared on arm, loaded by every kept sample.
    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (clear) begin
            prev_d       = '0;
            prev_valid_d = 1'b0;
        end else if (strobe) begin
            prev_d       = sample;
            prev_valid_d = 1'b1;
        end
    end

    // History registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign fire = strobe && !clear && prev_valid_q &&
                  edge_hit(prev_q, sample, level, falling);

endmodule

// File: rtl/sample_capture.sv
// Triggered ADC capture: arms on activate, waits for a level crossing (or a
// timeout when auto-trigger is enabled), then writes 2^SAMPLE_DEPTH decimated
// samples to memory through a registered one-cycle write port.
// Handshake: adc_valid qualifies adc_data for one cycle, there is no
// back-pressure; mem_we is a single-cycle strobe with mem_addr/mem_wdata
// valid in the same cycle.
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int SAMPLE_DEPTH = 10,
    parameter int AUTO_TIMEOUT = 5_000_000
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    activate,
    output logic                    done,
    input  logic [7:0]              adc_data,
    input  logic                    adc_valid,
    input  logic [7:0]              trig_level,
    input  logic                    trig_falling,
    input  logic                    trig_auto,
    input  logic [7:0]              decim,
    output logic                    triggered,
    output logic                    mem_we,
    output logic [SAMPLE_DEPTH-1:0] mem_addr,
    output logic [7:0]              mem_wdata,
    output state_e                  state_dbg
);

    localparam int TW = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [TW-1:0]           TO_LAST   = TW'(AUTO_TIMEOUT - 1);
    localparam logic [SAMPLE_DEPTH-1:0] ADDR_LAST = '1;

    state_e                  state_q, state_d;
    logic [7:0]              dcnt_q, dcnt_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic                    triggered_q, triggered_d;
    sample_t                 lvl_q, lvl_d;
    logic                    fall_q, fall_d;
    logic                    auto_q, auto_d;
    logic [7:0]              decim_q, decim_d;
    logic [SAMPLE_DEPTH-1:0] waddr_q, waddr_d;
    logic                    we_q, we_d;
    logic [SAMPLE_DEPTH-1:0] addr_q, addr_d;
    sample_t                 wdata_q, wdata_d;
    logic                    done_q, done_d;

    logic running;
    logic arm;
    logic strobe;
    logic det_strobe;
    logic fire;
    logic timeout_hit;

    assign running     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign arm         = (state_q == ST_IDLE) && activate;
    assign strobe      = running && adc_valid && (dcnt_q == 8'd0);
    assign det_strobe  = strobe && (state_q == ST_ARMED) && activate;
    assign timeout_hit = auto_q && (tcnt_q == TO_LAST);

    trigger_detect u_trigger_detect (
        .clk     (clk_50mhz),
        .rst_n   (reset),
        .clear   (arm),
        .strobe  (det_strobe),
        .sample  (adc_data),
        .level   (lvl_q),
        .falling (fall_q),
        .fire    (fire)
    );

    // Decimation counter: a zero count marks a kept sample and reloads.
    always_comb begin
        dcnt_d = dcnt_q;
        if (arm) begin
            dcnt_d = 8'd0;
        end else if (running && adc_valid) begin
            dcnt_d = (dcnt_q == 8'd0) ? decim_q : dcnt_q - 8'd1;
        end
    end

    // Auto-trigger timeout: counts ARMED cycles and saturates at the limit.
    always_comb begin
        tcnt_d = tcnt_q;
        if (arm) begin
            tcnt_d = '0;
        end else if ((state_q == ST_ARMED) && (tcnt_q != TO_LAST)) begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // FSM next state, configuration capture and write-port staging.
    always_comb begin
        state_d     = state_q;
        triggered_d = triggered_q;
        lvl_d       = lvl_q;
        fall_d      = fall_q;
        auto_d      = auto_q;
        decim_d     = decim_q;
        waddr_d     = waddr_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        done_d      = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (activate) begin
                    state_d     = ST_ARMED;
                    triggered_d = 1'b0;
                    waddr_d     = '0;
                    lvl_d       = trig_level;
                    fall_d      = trig_falling;
                    auto_d      = trig_auto;
                    decim_d     = decim;
                end
            end
            ST_ARMED: begin
                if (!activate) begin
                    state_d = ST_IDLE;
                end else if (strobe && (fire || timeout_hit)) begin
                    // A real crossing wins over a simultaneous timeout.
                    we_d        = 1'b1;
                    addr_d      = waddr_q;
                    wdata_d     = adc_data;
                    waddr_d     = waddr_q + SAMPLE_DEPTH'(1);
                    triggered_d = fire;
                    state_d     = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!activate) begin
                    state_d = ST_IDLE;
                end else if (strobe) begin
                    we_d    = 1'b1;
                    addr_d  = waddr_q;
                    wdata_d = adc_data;
                    waddr_d = waddr_q + SAMPLE_DEPTH'(1);
                    if (waddr_q == ADDR_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!activate) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dcnt_q      <= '0;
            tcnt_q      <= '0;
            triggered_q <= 1'b0;
            lvl_q       <= '0;
            fall_q      <= 1'b0;
            auto_q      <= 1'b0;
            decim_q     <= '0;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            tcnt_q      <= tcnt_d;
            triggered_q <= triggered_d;
            lvl_q       <= lvl_d;
            fall_q      <= fall_d;
            auto_q      <= auto_d;
            decim_q     <= decim_d;
            waddr_q     <= waddr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
        end
    end

    assign done      = done_q;
    assign triggered = triggered_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture with SAMPLE_DEPTH=4, AUTO_TIMEOUT=100.
module tb_sample_capture;
    import sample_capture_pkg::*;

    logic       clk;
    logic       reset;
    logic       activate;
    logic       done;
    logic [7:0] adc_data;
    logic       adc_valid;
    logic [7:0] trig_level;
    logic       trig_falling;
    logic       trig_auto;
    logic [7:0] decim;
    logic       triggered;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    state_e     state_dbg;

    int tests = 0;
    int failures = 0;
    int cyc = 0;
    int arm_cyc;
    int flag;

    logic [7:0] exp_q[$];
    logic [3:0] wa_q[$];
    logic [7:0] wd_q[$];
    int         ws_q[$];

    sample_capture #(.SAMPLE_DEPTH(4), .AUTO_TIMEOUT(100)) dut (
        .clk_50mhz    (clk),
        .reset        (reset),
        .activate     (activate),
        .done         (done),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .trig_auto    (trig_auto),
        .decim        (decim),
        .triggered    (triggered),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .state_dbg    (state_dbg)
    );

    // Clock and cycle stamp.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            ws_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic feed(input logic [7:0] d);
        @(negedge clk);
        adc_data  = d;
        adc_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    task automatic arm(input logic [7:0] lvl, input logic fall, input logic aut, input logic [7:0] dec);
        @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        ws_q.delete();
        exp_q.delete();
        trig_level   = lvl;
        trig_falling = fall;
        trig_auto    = aut;
        decim        = dec;
        activate     = 1'b1;
        arm_cyc      = cyc;
    endtask

    task automatic disarm();
        @(negedge clk);
        activate  = 1'b0;
        adc_valid = 1'b0;
        tick(3);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // Scoreboard: recorded writes against the expected data queue.
    task automatic check_record(input string tag);
        check({tag, "_count"}, 32'(wa_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wa_q.size(); i++) begin
            check({tag, "_addr"}, 32'(wa_q[i]), 32'(i));
            check({tag, "_data"}, 32'(wd_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        reset        = 1'b0;
        activate     = 1'b0;
        adc_data     = 8'h00;
        adc_valid    = 1'b0;
        trig_level   = 8'h00;
        trig_falling = 1'b0;
        trig_auto    = 1'b0;
        decim        = 8'h00;
        tick(3);

        // Reset state.
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_trig", 32'(triggered), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b1;
        tick(2);

        // Rising edge at 0x80, no decimation.
        arm(8'h80, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 18; i++) feed(8'(8'h70 + 8 * i));
        idle();
        wait_done("rise_done", 20);
        tick(1);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h80 + 8 * k));
        check_record("rise");
        check("rise_trig", 32'(triggered), 32'd1);
        flag = 1;
        for (int i = 1; i < ws_q.size(); i++) if (ws_q[i] - ws_q[i-1] != 1) flag = 0;
        check("rise_back_to_back", 32'(flag), 32'd1);
        disarm();
        check("rise_done_fall", 32'(done), 32'd0);
        check("rise_idle", 32'(state_dbg), 32'(ST_IDLE));

        // Falling edge at 0x40; a rising ramp through the level is ignored.
        arm(8'h40, 1'b1, 1'b0, 8'd0);
        feed(8'h30); feed(8'h38); feed(8'h40); feed(8'h48); feed(8'h50);
        idle();
        tick(2);
        check("fall_no_rise_writes", 32'(wa_q.size()), 32'd0);
        check("fall_still_armed", 32'(state_dbg), 32'(ST_ARMED));
        feed(8'h40);
        for (int i = 1; i < 16; i++) feed(8'(8'h40 - i));
        idle();
        wait_done("fall_done", 20);
        tick(1);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h40 - k));
        check_record("fall");
        check("fall_trig", 32'(triggered), 32'd1);
        disarm();

        // Decimation by 3: kept samples 0,3,..,15 then 18 crosses 0x10.
        arm(8'h10, 1'b0, 1'b0, 8'd2);
        for (int i = 0; i < 80; i++) feed(8'(i));
        idle();
        wait_done("decim_done", 20);
        tick(1);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(18 + 3 * k));
        check_record("decim");
        flag = 1;
        for (int i = 1; i < ws_q.size(); i++) if (ws_q[i] - ws_q[i-1] != 3) flag = 0;
        check("decim_spacing", 32'(flag), 32'd1);
        disarm();

        // Auto-trigger on a flat input.
        arm(8'h80, 1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 130; i++) feed(8'h20);
        idle();
        wait_done("auto_done", 20);
        tick(1);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'h20);
        check_record("auto");
        check("auto_trig", 32'(triggered), 32'd0);
        if (ws_q.size() > 0) begin
            check("auto_latency_ok", 32'((ws_q[0] - arm_cyc >= 95) && (ws_q[0] - arm_cyc <= 105)), 32'd1);
        end else begin
            check("auto_first_write", 32'd0, 32'd1);
        end
        disarm();

        // Abort after five writes.
        arm(8'h80, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) feed(8'(8'h70 + 8 * i));
        disarm();
        check("abort_writes", 32'(wa_q.size()), 32'd5);
        check("abort_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("abort_done", 32'(done), 32'd0);
        feed(8'h70); feed(8'h90); feed(8'hB0);
        idle();
        tick(2);
        check("abort_no_more", 32'(wa_q.size()), 32'd5);

        // Reset mid-capture.
        arm(8'h80, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 6; i++) feed(8'(8'h70 + 8 * i));
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rstmid_we", 32'(mem_we), 32'd0);
        check("rstmid_addr", 32'(mem_addr), 32'd0);
        check("rstmid_wdata", 32'(mem_wdata), 32'd0);
        check("rstmid_trig", 32'(triggered), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_state", 32'(state_dbg), 32'(ST_IDLE));
        feed(8'hA0); feed(8'hA8); feed(8'hB0);
        idle();
        tick(2);
        check("rstmid_writes", 32'(wa_q.size()), 32'd3);
        activate = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        check("post_rst_idle", 32'(state_dbg), 32'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter SAMPLE_DEPTH, default 10: sample memory address width; the buffer holds 2^SAMPLE_DEPTH samples.
REQ-002 Parameter AUTO_TIMEOUT, default 5_000_000: clk_50mhz cycles spent ARMED before an auto-trigger.
REQ-003 clk_50mhz  in  1: single clock, all logic on the rising edge.
REQ-004 reset  in  1: asynchronous, active-low reset.
REQ-005 activate  in  1: level request to arm and capture one record.
REQ-006 done  out  1: record complete; held high until activate falls.
REQ-007 adc_data  in  8: ADC sample.
REQ-008 adc_valid  in  1: adc_data is valid this cycle.
REQ-009 trig_level  in  8: unsigned trigger threshold.
REQ-010 trig_falling  in  1: 0 = rising-edge trigger, 1 = falling-edge trigger.
REQ-011 trig_auto  in  1: enable the timeout auto-trigger.
REQ-012 decim  in  8: keep one valid sample in every decim+1.
REQ-013 triggered  out  1: the current or last record began on a real level crossing, not a timeout.
REQ-014 mem_we  out  1: one-cycle write strobe.
REQ-015 mem_addr  out  SAMPLE_DEPTH: write address.
REQ-016 mem_wdata  out  8: write data.

Function
REQ-017 The block SHALL implement states IDLE, ARMED, CAPTURE and DONE.
REQ-018 IDLE -> ARMED when activate=1; on entry clear the decimation counter, the prev_valid flag, the timeout counter and triggered.
REQ-019 A strobe SHALL occur on an adc_valid cycle when the decimation counter is 0.
  - Each adc_valid cycle reloads the counter to decim if it is 0, otherwise decrements it.
  - decim=0 makes every valid sample a strobe.
REQ-020 In ARMED, each strobe SHALL store adc_data into prev and set prev_valid.
  - The first strobe after arming never triggers.
REQ-021 The rising trigger SHALL fire when prev_valid, prev < trig_level and adc_data >= trig_level, compared as 8-bit unsigned values.
  - The falling trigger uses prev > trig_level and adc_data <= trig_level.
REQ-022 On trigger: write the triggering sample at address 0, set triggered=1 and move to CAPTURE.
REQ-023 If trig_auto=1 and the timeout counter reaches AUTO_TIMEOUT-1 in ARMED:
  - the next strobe is written at address 0 with triggered=0, and the state moves to CAPTURE;
  - the counter then saturates.
REQ-024 In CAPTURE, each strobe SHALL write the sample at the next address, incrementing by 1.
REQ-025 Write latency SHALL be exactly one cycle: a strobe at cycle N gives mem_we=1 at cycle N+1, with mem_addr/mem_wdata valid in the same cycle.
REQ-026 mem_we SHALL never be high on two consecutive cycles unless strobes occur on consecutive cycles.
REQ-027 After the write to address 2^SAMPLE_DEPTH-1, the state SHALL move to DONE and assert done on the following cycle.
  - Exactly 2^SAMPLE_DEPTH writes occur per record; the address never wraps.
REQ-028 In DONE, done=1 and no writes occur; DONE -> IDLE when activate=0, and done falls the cycle after.
REQ-029 If activate falls in ARMED or CAPTURE, the block SHALL abort to IDLE without asserting done.
  - A write already registered still completes.
REQ-030 A trigger and the auto-timeout in the same strobe SHALL resolve as a real trigger (triggered=1).
REQ-031 trig_level, trig_falling, trig_auto and decim SHALL be sampled on IDLE -> ARMED and held for the record.

Reset
REQ-032 While reset=0: state=IDLE; done, mem_we, triggered, mem_addr, mem_wdata, prev, prev_valid and all counters = 0.
REQ-033 Reset asserted mid-capture SHALL take effect immediately, with no further writes.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE, ARMED, CAPTURE, DONE) and the 8-bit sample typedef, for reuse by sample_reader.
REQ-035 Trigger detection (prev register, prev_valid, edge compare) SHALL be a sub-module named trigger_detect.

Verification
REQ-036 Bench scenarios (SAMPLE_DEPTH=4, AUTO_TIMEOUT=100):
  - Rising edge: level=0x80, decim=0, ramp 0x70,0x78,0x80,0x88... -> sample 0x80 at addr 0, 16 writes ending 0xF8 at addr 15, done, triggered=1.
  - Falling edge: trig_falling=1, level=0x40, samples 0x50,0x40 -> 0x40 at addr 0; a rising ramp through 0x40 gives no trigger.
  - Decimation: decim=2, continuous valid ramp 0..255 with trigger at 0x10 -> writes at addr 0..15 spaced 3 samples apart.
  - Auto-trigger: trig_auto=1, constant 0x20 input -> first write about 100 cycles after arm, triggered=0, 16 writes, done.
  - Abort and reset: activate falls after 5 writes -> IDLE, done stays 0; reset=0 mid-capture -> mem_we=0 immediately, all outputs 0.
